result_drain: RTL and testbench

//  Downstream unloader for the multicycle matrix-vector CPU. Waits for the CPU's done level to rise.

---
 rtl/result_drain.sv | 167 ++++++++++++++++
 tb/tb_result_drain.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// Drains the CPU's byte-wide output RAM as big-endian 32-bit words onto a valid/ready stream,
// optionally followed by a trailer word carrying the CPU cycle count captured at done.
module result_drain #(
  parameter int          ROWS        = 4,
  parameter int          ADDR_W      = 4,
  parameter int          TRAILER     = 1,
  parameter logic [15:0] TRAILER_TAG = 16'hFEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_in,
  input  logic [15:0]       cycles_in,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_data,
  output logic              m_last,
  output logic [15:0]       word_count,
  output logic              drain_done,
  output logic [2:0]        state_dbg
);

  // Stream handshake: a word transfers on any posedge where m_valid & m_ready; while m_valid is
  // high and m_ready is low, m_data and m_last are held unchanged.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_PRESENT = 3'd2;
  localparam logic [2:0] S_TRAIL   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * 4 - 1);

  logic [2:0]        state_q, state_d;
  logic              done_q, done_d;
  logic [15:0]       cyc_q, cyc_d;
  logic [2:0]        ph_q, ph_d;
  logic [23:0]       sr_q, sr_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [31:0]       data_q, data_d;
  logic              last_q, last_d;
  logic [15:0]       wc_q, wc_d;

  logic        start;
  logic        hs;
  logic [15:0] wc_inc;

  always_comb begin
    state_d = state_q;
    done_d  = done_in;
    cyc_d   = cyc_q;
    ph_d    = ph_q;
    sr_d    = sr_q;
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    wc_d    = wc_q;
    start   = done_in & ~done_q;
    hs      = valid_q & m_ready;
    wc_inc  = (wc_q == 16'hFFFF) ? wc_q : wc_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cyc_d   = cycles_in;
          wc_d    = 16'd0;
          rd_en_d = 1'b1;
          addr_d  = '0;
          ph_d    = 3'd0;
        end
      end
      S_FETCH: begin
        // ph counts cycles since the first read; byte data lags its strobe by one cycle.
        ph_d = ph_q + 3'd1;
        if (ph_q < 3'd3) begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + 1'b1;
        end
        if (ph_q >= 3'd1 && ph_q <= 3'd3) begin
          sr_d = {sr_q[15:0], ram_rdata};
        end
        if (ph_q == 3'd4) begin
          state_d = S_PRESENT;
          data_d  = {sr_q, ram_rdata};
          valid_d = 1'b1;
          last_d  = (TRAILER == 0) && (addr_q == LAST_ADDR);
        end
      end
      S_PRESENT: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          wc_d    = wc_inc;
          if (addr_q != LAST_ADDR) begin
            state_d = S_FETCH;
            rd_en_d = 1'b1;
            addr_d  = addr_q + 1'b1;
            ph_d    = 3'd0;
          end else if (TRAILER != 0) begin
            state_d = S_TRAIL;
            valid_d = 1'b1;
            data_d  = {TRAILER_TAG, cyc_q};
            last_d  = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_TRAIL: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          wc_d    = wc_inc;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!done_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      cyc_q   <= 16'd0;
      ph_q    <= 3'd0;
      sr_q    <= 24'd0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      last_q  <= 1'b0;
      wc_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
      ph_q    <= ph_d;
      sr_q    <= sr_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      wc_q    <= wc_d;
    end
  end

  assign ram_rd_en  = rd_en_q;
  assign ram_addr   = addr_q;
  assign m_valid    = valid_q;
  assign m_data     = data_q;
  assign m_last     = last_q;
  assign word_count = wc_q;
  assign drain_done = (state_q == S_DONE);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: one instance with trailer, one without, each with its own
// byte RAM model and a scoreboard of expected {last, data} words.
module tb_result_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        done_in, done0;
  logic [15:0] cycles_in;
  logic        m_ready, ready0;

  logic        ram_rd_en, rd_en0;
  logic [3:0]  ram_addr, addr0;
  logic [7:0]  ram_rdata, rdata0;
  logic        m_valid, valid0;
  logic [31:0] m_data, data0;
  logic        m_last, last0;
  logic [15:0] word_count, wc0;
  logic        drain_done, dd0;
  logic [2:0]  state_dbg, state0;

  logic [7:0]  mem [0:15];
  logic [32:0] exp_q[$];
  logic [32:0] exp0_q[$];
  int          total = 0;
  int          bad = 0;
  int          rd_cnt = 0;
  int          snap;

  always #5 clk = ~clk;

  result_drain #(.ROWS(4), .ADDR_W(4), .TRAILER(1), .TRAILER_TAG(16'hFEED)) dut (
    .clk(clk), .rst(rst), .done_in(done_in), .cycles_in(cycles_in),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .word_count(word_count), .drain_done(drain_done), .state_dbg(state_dbg)
  );

  result_drain #(.ROWS(4), .ADDR_W(4), .TRAILER(0), .TRAILER_TAG(16'hFEED)) dut0 (
    .clk(clk), .rst(rst), .done_in(done0), .cycles_in(cycles_in),
    .ram_rd_en(rd_en0), .ram_addr(addr0), .ram_rdata(rdata0),
    .m_valid(valid0), .m_ready(ready0), .m_data(data0), .m_last(last0),
    .word_count(wc0), .drain_done(dd0), .state_dbg(state0)
  );

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    ram_rdata = 8'h00;
    rdata0    = 8'h00;
  end

  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
    if (rd_en0)    rdata0    <= mem[addr0];
  end

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboards and stream invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("last_without_valid", {32'd0, m_last & ~m_valid}, 33'd0);
      check("last_without_valid0", {32'd0, last0 & ~valid0}, 33'd0);
      if (ram_rd_en) rd_cnt++;
      if (m_valid && m_ready) begin
        check("sb_has_entry", {32'd0, exp_q.size() != 0}, 33'd1);
        if (exp_q.size() != 0) check("stream_word", {m_last, m_data}, exp_q.pop_front());
      end
      if (valid0 && ready0) begin
        check("sb0_has_entry", {32'd0, exp0_q.size() != 0}, 33'd1);
        if (exp0_q.size() != 0) check("stream_word0", {last0, data0}, exp0_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_drain(input logic [15:0] cyc);
    exp_q.push_back({1'b0, 32'h00010203});
    exp_q.push_back({1'b0, 32'h04050607});
    exp_q.push_back({1'b0, 32'h08090A0B});
    exp_q.push_back({1'b0, 32'h0C0D0E0F});
    exp_q.push_back({1'b1, 16'hFEED, cyc});
  endtask

  task automatic wait_done(input bit sel);
    int n = 0;
    while (((sel ? dd0 : drain_done) !== 1'b1) && n < 300) begin
      tick();
      n++;
    end
    check(sel ? "timeout_drain_done0" : "timeout_drain_done", {32'd0, n < 300}, 33'd1);
  endtask

  task automatic wait_wc(input logic [15:0] v);
    int n = 0;
    while (word_count !== v && n < 300) begin
      tick();
      n++;
    end
    check("timeout_word_count", {32'd0, n < 300}, 33'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (m_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("timeout_m_valid", {32'd0, n < 300}, 33'd1);
  endtask

  initial begin
    rst = 1'b1; done_in = 1'b0; done0 = 1'b0; cycles_in = 16'h0000;
    m_ready = 1'b1; ready0 = 1'b1;
    repeat (3) tick();
    check("rst_m_valid", {32'd0, m_valid}, 33'd0);
    check("rst_m_last", {32'd0, m_last}, 33'd0);
    check("rst_rd_en", {32'd0, ram_rd_en}, 33'd0);
    check("rst_drain_done", {32'd0, drain_done}, 33'd0);
    check("rst_addr", {29'd0, ram_addr}, 33'd0);
    check("rst_m_data", {1'b0, m_data}, 33'd0);
    check("rst_word_count", {17'd0, word_count}, 33'd0);
    rst = 1'b0;
    tick();

    // Single-cycle done pulse: exact read and valid latency, cycles captured at the edge.
    push_drain(16'h0123);
    cycles_in = 16'h0123; done_in = 1'b1;
    tick();
    done_in = 1'b0; cycles_in = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      check("lat_rd_en", {32'd0, ram_rd_en}, 33'd1);
      check("lat_addr", {29'd0, ram_addr}, 33'(i));
      tick();
    end
    check("lat_rd_en_off", {32'd0, ram_rd_en}, 33'd0);
    check("lat_valid_early", {32'd0, m_valid}, 33'd0);
    tick();
    check("lat_valid_rise", {32'd0, m_valid}, 33'd1);
    check("lat_first_word", {1'b0, m_data}, {1'b0, 32'h00010203});
    wait_done(1'b0);
    check("pulse_word_count", {17'd0, word_count}, 33'd5);
    tick(); tick();

    // Level done, sink always ready.
    push_drain(16'h0123);
    cycles_in = 16'h0123; done_in = 1'b1;
    wait_done(1'b0);
    check("t1_word_count", {17'd0, word_count}, 33'd5);
    check("t1_valid_low", {32'd0, m_valid}, 33'd0);

    // Held done must not retrigger; low-then-high replays.
    snap = rd_cnt;
    repeat (50) tick();
    check("t3_no_reads", 33'(rd_cnt), 33'(snap));
    check("t3_still_done", {32'd0, drain_done}, 33'd1);
    done_in = 1'b0;
    tick();
    done_in = 1'b1;
    push_drain(16'h0123);
    tick();
    check("t3_wc_cleared", {17'd0, word_count}, 33'd0);
    wait_valid();
    tick();
    check("t3_wc_restart", {17'd0, word_count}, 33'd1);
    wait_done(1'b0);
    check("t3_word_count", {17'd0, word_count}, 33'd5);

    // Sink stalls three cycles on word 1.
    done_in = 1'b0; tick(); tick();
    push_drain(16'h0456);
    cycles_in = 16'h0456; done_in = 1'b1;
    wait_wc(16'd1);
    m_ready = 1'b0;
    wait_valid();
    snap = rd_cnt;
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_valid", {32'd0, m_valid}, 33'd1);
      check("t2_hold_data", {1'b0, m_data}, {1'b0, 32'h04050607});
      tick();
    end
    check("t2_no_reads", 33'(rd_cnt), 33'(snap));
    m_ready = 1'b1;
    wait_done(1'b0);
    check("t2_word_count", {17'd0, word_count}, 33'd5);

    // Reset mid-drain, done still high: fresh drain from address 0.
    done_in = 1'b0; tick(); tick();
    exp_q.push_back({1'b0, 32'h00010203});
    exp_q.push_back({1'b0, 32'h04050607});
    push_drain(16'h0789);
    cycles_in = 16'h0789; done_in = 1'b1;
    wait_wc(16'd2);
    rst = 1'b1;
    tick();
    check("t4_valid_after_rst", {32'd0, m_valid}, 33'd0);
    check("t4_rd_en_after_rst", {32'd0, ram_rd_en}, 33'd0);
    rst = 1'b0;
    tick();
    check("t4_restart_rd_en", {32'd0, ram_rd_en}, 33'd1);
    check("t4_restart_addr", {29'd0, ram_addr}, 33'd0);
    wait_done(1'b0);
    check("t4_word_count", {17'd0, word_count}, 33'd5);
    done_in = 1'b0;

    // No trailer: four words, last on the final result word.
    exp0_q.push_back({1'b0, 32'h00010203});
    exp0_q.push_back({1'b0, 32'h04050607});
    exp0_q.push_back({1'b0, 32'h08090A0B});
    exp0_q.push_back({1'b1, 32'h0C0D0E0F});
    done0 = 1'b1;
    wait_done(1'b1);
    check("t5_word_count", {17'd0, wc0}, 33'd4);
    check("t5_valid_low", {32'd0, valid0}, 33'd0);
    done0 = 1'b0;
    tick(); tick();

    check("sb_drained", 33'(exp_q.size()), 33'd0);
    check("sb0_drained", 33'(exp0_q.size()), 33'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
